// File: rtl/adder_result_rx.sv
// Receive side of the valid-strobed adder result stream: captures strobed sums into a
// small FIFO, re-emits them on an AXI-Stream master and grants issue credit upstream.
module adder_result_rx #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_i,
    input  logic                   valid_i,
    input  logic [WIDTH:0]         data_i,
    output logic                   space_o,
    output logic                   m_tvalid_o,
    output logic [WIDTH:0]         m_tdata_o,
    input  logic                   m_tready_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] INF_MAX  = '1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic          overflow_q, overflow_d;

    logic          pop_c;
    logic          push_c;
    logic [CW:0]   occupancy_c;

    // A full FIFO still takes a word when the head leaves in the same cycle.
    always_comb begin
        pop_c       = (count_q != '0) && m_tready_i;
        push_c      = valid_i && ((count_q != FULL_CNT) || pop_c);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        inflight_d  = inflight_q;
        overflow_d  = overflow_q;
        occupancy_c = (CW+1)'(count_q) + (CW+1)'(inflight_q);

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (valid_i && !push_c) begin
            overflow_d = 1'b1;
        end

        // Late results after a flush must not drive the credit count negative.
        if (issue_i && !valid_i && (inflight_q != INF_MAX)) begin
            inflight_d = inflight_q + CW'(1);
        end else if (valid_i && !issue_i && (inflight_q != '0)) begin
            inflight_d = inflight_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; the head word is only meaningful while m_tvalid_o is high.
    always_ff @(posedge clk) begin
        if (!reset && push_c) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign m_tvalid_o = (count_q != '0);
    assign m_tdata_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign space_o    = !reset && (occupancy_c < (CW+1)'(DEPTH));

endmodule

// File: tb/tb_adder_result_rx.sv
// Directed and randomized bench for adder_result_rx against a queue-based reference model.
module tb_adder_result_rx;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam int          INF_MAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          issue_i;
    logic          valid_i;
    logic [WIDTH:0] data_i;
    logic          space_o;
    logic          m_tvalid_o;
    logic [WIDTH:0] m_tdata_o;
    logic          m_tready_i;
    logic [CW-1:0] count_o;
    logic          overflow_o;

    adder_result_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .issue_i    (issue_i),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .space_o    (space_o),
        .m_tvalid_o (m_tvalid_o),
        .m_tdata_o  (m_tdata_o),
        .m_tready_i (m_tready_i),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int q[$];
    int got[$];
    int inflight;
    bit ovf;
    bit rst_cur;
    int n_pass;
    int n_fail;
    int n_total;
    bit pv[2];
    int pd[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        check("tvalid", 32'(m_tvalid_o), 32'(sz != 0));
        check("count", 32'(count_o), 32'(sz));
        check("overflow", 32'(overflow_o), 32'(ovf));
        check("space", 32'(space_o), 32'(!rst_cur && (sz + inflight < DEPTH)));
        if (sz != 0) check("tdata", 32'(m_tdata_o), 32'(q[0]));
    endtask

    task automatic model_step(input bit rst, input bit iss, input bit vld, input int dat, input bit rdy);
        bit pop;
        bit acc;
        if (rst) begin
            q.delete();
            inflight = 0;
            ovf = 1'b0;
        end else begin
            pop = (q.size() != 0) && rdy;
            acc = vld && ((q.size() < DEPTH) || pop);
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(dat);
            else if (vld) ovf = 1'b1;
            if (iss && !vld && inflight < INF_MAX) inflight++;
            else if (vld && !iss && inflight > 0) inflight--;
        end
        rst_cur = rst;
    endtask

    // One clock: check current outputs, drive next inputs, advance the model.
    task automatic cyc(input bit rst, input bit iss, input bit vld, input int dat, input bit rdy);
        @(negedge clk);
        check_all();
        reset      = rst;
        issue_i    = iss;
        valid_i    = vld;
        data_i     = (WIDTH+1)'(dat);
        m_tready_i = rdy;
        if (!rst && m_tvalid_o && rdy) got.push_back(int'(m_tdata_o));
        model_step(rst, iss, vld, dat, rdy);
    endtask

    // Upstream source feeding a 2-cycle adder pipeline, optionally honouring space.
    task automatic adder_cyc(input bit rst, input bit want, input bit rdy, input bit obey, output bit issued);
        bit space_now;
        space_now = !rst && (q.size() + inflight < DEPTH);
        issued = want && (space_now || !obey);
        cyc(rst, issued, pv[1], pd[1], rdy);
        pv[1] = pv[0];
        pd[1] = pd[0];
        pv[0] = issued;
        pd[0] = int'($urandom_range(0, 31));
    endtask

    initial begin
        bit iss_done;
        int n_iss;
        n_pass = 0;
        n_fail = 0;
        n_total = 0;
        pv = '{0, 0};
        pd = '{0, 0};
        reset = 1'b1;
        issue_i = 1'b0;
        valid_i = 1'b0;
        data_i = '0;
        m_tready_i = 1'b0;
        q.delete();
        inflight = 0;
        ovf = 1'b0;
        rst_cur = 1'b1;

        // Reset then basic pass-through
        cyc(1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 5, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Backpressure fill and ordered drain
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, i, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        got.delete();
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
        check("drain_len", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("drain_order", 32'(got[i]), 32'(i + 1));

        // Full with simultaneous push/pop, then a dropped push
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, i, 0);
        cyc(0, 0, 1, 9, 1);
        cyc(0, 0, 1, 9, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Reset mid-stream, then a late result
        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) cyc(0, 0, 1, 10 + i, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 7, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Wrap-around with ready toggling
        got.delete();
        for (int i = 0; i < 20; i++) cyc(0, 0, (i % 2) == 0, i / 2, (i % 2) == 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);
        check("wrap_len", 32'(got.size()), 32'd10);
        for (int i = 0; i < 10 && i < got.size(); i++) check("wrap_order", 32'(got[i]), 32'(i));

        // Credit throttling through the 2-cycle adder, ready held low
        cyc(1, 0, 0, 0, 0);
        n_iss = 0;
        for (int i = 0; i < 20; i++) begin
            adder_cyc(0, 1, 0, 1, iss_done);
            if (iss_done) n_iss++;
        end
        check("credit_issues", 32'(n_iss), 32'd4);
        check("credit_no_ovf", 32'(overflow_o), 32'd0);
        for (int i = 0; i < 8; i++) adder_cyc(0, 0, 1, 1, iss_done);

        // Randomized traffic, mostly protocol-abiding
        for (int i = 0; i < 400; i++) begin
            adder_cyc(($urandom % 100) == 0, ($urandom % 10) < 6, ($urandom % 3) != 0,
                      ($urandom % 40) != 0, iss_done);
        end
        for (int i = 0; i < 10; i++) adder_cyc(0, 0, 1, 1, iss_done);

        @(negedge clk);
        check_all();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
